shift_div_pipe: RTL and testbench



---
 rtl/shift_div_pipe.sv | 123 ++++++++++++
 tb/tb_shift_div_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_div_pipe.sv
// Three-stage pipelined power-of-two divider: quotient = d >> k, remainder = d mod 2^k.
// Optional build macro SHIFT_DIV_ROUND_EN rounds the quotient half-up in the last stage.
module shift_div_pipe #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_k,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_q,
  output logic [DATA_W-1:0] out_r,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  // Inner stages still need the exponent bits; the output stage does not.
  typedef struct packed {
    logic              v;
    logic [2:0]        k;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    logic [TAG_W-1:0]  tag;
  } out_stage_t;

  stage_t     r_s1, r_s2, w_s1_nxt, w_s2_nxt;
  out_stage_t r_s3, w_s3_nxt;

  logic              w_s1_load, w_s2_load, w_s3_load, w_accept;
  logic [DATA_W-1:0] w_s2_bits, w_s3_bit, w_s3_q, w_s3_r;

  // A stage loads when it is empty or its content moves on this cycle.
  assign w_s3_load = !r_s3.v || out_ready;
  assign w_s2_load = !r_s2.v || w_s3_load;
  assign w_s1_load = !r_s1.v || w_s2_load;
  assign in_ready  = rst_n && w_s1_load;
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    // NOTE: every variable gets a default at the top of the block so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    w_s1_nxt = r_s1;
    if (w_s1_load) begin
      w_s1_nxt.v = w_accept;
      if (w_accept) begin
        w_s1_nxt.k   = in_k;
        w_s1_nxt.tag = in_tag;
        w_s1_nxt.q   = in_k[2] ? (in_data >> 4) : in_data;
        w_s1_nxt.r   = in_k[2] ? {{(DATA_W-4){1'b0}}, in_data[3:0]} : '0;
      end
    end
  end

  always_comb begin
    w_s2_bits = DATA_W'(r_s1.q[1:0]) << {r_s1.k[2], 2'b00};
    w_s2_nxt  = r_s2;
    if (w_s2_load) begin
      w_s2_nxt.v = r_s1.v;
      if (r_s1.v) begin
        w_s2_nxt = r_s1;
        if (r_s1.k[1]) begin
          w_s2_nxt.q = r_s1.q >> 2;
          w_s2_nxt.r = r_s1.r | w_s2_bits;
        end
      end
    end
  end

  always_comb begin
    w_s3_bit = DATA_W'(r_s2.q[0]) << {r_s2.k[2], r_s2.k[1], 1'b0};
    w_s3_q   = r_s2.k[0] ? (r_s2.q >> 1) : r_s2.q;
    w_s3_r   = r_s2.k[0] ? (r_s2.r | w_s3_bit) : r_s2.r;
`ifdef SHIFT_DIV_ROUND_EN
    // Remainder bit k-1 set means r >= 2^(k-1); q < 2^(DATA_W-1) so no overflow.
    if ((r_s2.k != 3'd0) && w_s3_r[r_s2.k - 3'd1])
      w_s3_q = w_s3_q + {{(DATA_W-1){1'b0}}, 1'b1};
`endif
    w_s3_nxt = r_s3;
    if (w_s3_load) begin
      w_s3_nxt.v = r_s2.v;
      if (r_s2.v) begin
        w_s3_nxt.q   = w_s3_q;
        w_s3_nxt.r   = w_s3_r;
        w_s3_nxt.tag = r_s2.tag;
      end
    end
  end

  // NOTE: data fields are reset along with the valid bits because the output
  // stage drives the ports directly and must read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value
      // of its predecessor, regardless of statement order.
      r_s1 <= w_s1_nxt;
      r_s2 <= w_s2_nxt;
      r_s3 <= w_s3_nxt;
    end
  end

  assign out_valid = r_s3.v;
  assign out_q     = r_s3.q;
  assign out_r     = r_s3.r;
  assign out_tag   = r_s3.tag;
  assign busy      = r_s1.v | r_s2.v | r_s3.v;

endmodule

// File: tb/tb_shift_div_pipe.sv
// Scoreboard bench for shift_div_pipe: the driver queues expected results on accept,
// an independent monitor pops and compares on every output transfer.
module tb_shift_div_pipe;
  localparam int DW = 8;
  localparam int TW = 4;
`ifdef SHIFT_DIV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [2:0]    in_k = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_q, out_r;
  logic [TW-1:0] out_tag;
  logic          busy;

  shift_div_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_k(in_k), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [2:0]    k;
    logic [TW-1:0] tag;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
  } op_t;

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic [TW-1:0] tag;
  } exp_t;

  op_t         pend[$];
  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          n_acc = 0;
  int          si = 0;
  logic [31:0] ov_hist = '0;
  bit          rand_mode = 1'b0;
  logic        or_fix = 1'b1;
  logic [DW-1:0] hold_q, hold_r;
  logic [TW-1:0] hold_tag;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [DW-1:0] d, input logic [2:0] k, input logic [TW-1:0] tag,
                     input logic [DW-1:0] q, input logic [DW-1:0] r);
    op_t o;
    o.d = d; o.k = k; o.tag = tag; o.q = q; o.r = r;
    pend.push_back(o);
  endtask

  // Arithmetic reference used only for the random phase.
  task automatic add_model(input logic [DW-1:0] d, input logic [2:0] k, input logic [TW-1:0] tag);
    logic [DW-1:0] q, r, mask;
    mask = (DW'(1) << k) - DW'(1);
    q = d >> k;
    r = d & mask;
    if (RND && k != 3'd0 && r >= (DW'(1) << (k - 3'd1))) q = q + DW'(1);
    add(d, k, tag, q, r);
  endtask

  // One clock: drive after the rising edge, sample the handshake at the falling edge.
  task automatic step();
    in_valid = (pend.size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
    if (pend.size() > 0) begin
      in_data = pend[0].d;
      in_k    = pend[0].k;
      in_tag  = pend[0].tag;
    end
    out_ready = rand_mode ? ($urandom_range(0, 2) != 0) : or_fix;
    @(negedge clk);
    if (si < 32) ov_hist[si] = out_valid;
    si++;
    if (in_valid && in_ready) begin
      exp_t e;
      e.q = pend[0].q; e.r = pend[0].r; e.tag = pend[0].tag;
      sb.push_back(e);
      void'(pend.pop_front());
      n_acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_until_sent(input int max_steps);
    int n;
    n = 0;
    while (pend.size() > 0 && n < max_steps) begin
      step();
      n++;
    end
    check("all_operands_accepted", pend.size(), 0);
  endtask

  task automatic drain(input int max_steps);
    int n;
    n = 0;
    or_fix = 1'b1;
    while (sb.size() > 0 && n < max_steps) begin
      step();
      n++;
    end
    check("drain_scoreboard_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        check("unexpected_output", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_q", out_q, e.q);
        check("out_r", out_r, e.r);
        check("out_tag", out_tag, e.tag);
      end
    end
  end

  initial begin
    logic [DW-1:0] thr_q [8];
    // Reset with in_valid asserted.
    in_valid = 1'b1;
    in_data  = 8'hB7;
    in_k     = 3'd5;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_q", out_q, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_tag", out_tag, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: operand driven after edge E0, accepted at E1, visible after E3.
    si = 0; ov_hist = '0; or_fix = 1'b1;
    add(8'hB7, 3'd5, 4'h1, RND ? 8'h06 : 8'h05, 8'h17);
    repeat (5) step();
    check("latency_pattern", ov_hist[4:0], 5'b01000);

    // Boundaries.
    add(8'hFF, 3'd0, 4'h2, 8'hFF, 8'h00);
    add(8'h80, 3'd7, 4'h3, 8'h01, 8'h00);
    add(8'h40, 3'd7, 4'h4, RND ? 8'h01 : 8'h00, 8'h40);
    add(8'h00, 3'd3, 4'h5, 8'h00, 8'h00);
    run_until_sent(20);
    drain(20);

    // Throughput: 8 back-to-back, out_valid on 8 consecutive samples.
    if (RND) thr_q = '{8'h08, 8'h09, 8'h09, 8'h0A, 8'h0A, 8'h0B, 8'h0B, 8'h0C};
    else     thr_q = '{8'h08, 8'h08, 8'h09, 8'h09, 8'h0A, 8'h0A, 8'h0B, 8'h0B};
    for (int i = 0; i < 8; i++)
      add(8'h10 + DW'(i), 3'd1, TW'(i), thr_q[i], DW'(i % 2));
    si = 0; ov_hist = '0; n_acc = 0;
    repeat (8) step();
    check("thr_accepts_back_to_back", n_acc, 8);
    repeat (4) step();
    check("thr_out_valid_pattern", ov_hist[11:0], 12'h7F8);
    drain(20);

    // Backpressure: three accepted, outputs frozen on the first result.
    or_fix = 1'b0; n_acc = 0;
    add(8'h9C, 3'd2, 4'h8, 8'h27, 8'h00);
    add(8'h3B, 3'd3, 4'h9, 8'h07, 8'h03);
    add(8'hF0, 3'd4, 4'hA, 8'h0F, 8'h00);
    add(8'h65, 3'd6, 4'hB, RND ? 8'h02 : 8'h01, 8'h25);
    add(8'h2D, 3'd1, 4'hC, RND ? 8'h17 : 8'h16, 8'h01);
    repeat (4) step();
    check("bp_accepted", n_acc, 3);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_q", out_q, 8'h27);
    check("bp_out_tag", out_tag, 4'h8);
    hold_q = out_q; hold_r = out_r; hold_tag = out_tag;
    repeat (2) step();
    check("bp_accepted_still", n_acc, 3);
    check("bp_hold_q", out_q, hold_q);
    check("bp_hold_r", out_r, hold_r);
    check("bp_hold_tag", out_tag, hold_tag);
    or_fix = 1'b1;
    run_until_sent(20);
    drain(20);
    check("bp_total_accepted", n_acc, 5);

    // Reset mid-flight: two entries in S1/S2 are discarded.
    add(8'hAA, 3'd2, 4'hD, 8'h2A, 8'h02);
    add(8'h55, 3'd3, 4'hE, 8'h0A, 8'h05);
    repeat (2) step();
    check("mid_busy_before_reset", busy, 1);
    #3;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_busy_async", busy, 0);
    check("mid_out_valid_async", out_valid, 0);
    check("mid_in_ready_async", in_ready, 0);
    pend.delete();
    sb.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (8) step();
    check("mid_busy_after", busy, 0);

    // Random traffic with random valid and ready.
    for (int i = 0; i < 1000; i++)
      add_model(DW'($urandom), 3'($urandom_range(0, 7)), TW'($urandom));
    rand_mode = 1'b1;
    run_until_sent(20000);
    rand_mode = 1'b0;
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
